memory_banked_handshake: RTL and testbench
==========================================

Name: memory_banked_handshake

Overview:
Parametrised, multi-bank successor to the single-port handshake SRAM model. It adds per-byte write strobes, a registered response channel with backpressure, out-of-range error reporting and a hardware clear engine. It sits between a bus master (valid/ready requester) and on-chip storage. Every accepted request, read or write, returns exactly one response beat.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of 8.
DEPTH, 16, number of words; must be a multiple of NUM_BANKS; need not be a power of 2.
ADDR_WIDTH, 4, request address width; must be at least clog2(DEPTH).
NUM_BANKS, 2, number of interleaved banks; must be a power of 2, minimum 1.
INIT_ON_RESET, 1, 1 = start a clear sequence automatically when reset is released.

Ports:
clk_i  in  1  single clock; rising edge.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  request valid.
ready_o  out  1  request ready; a transfer occurs when valid_i && ready_o.
wr_rd_i  in  1  1 = write, 0 = read.
addr_i  in  ADDR_WIDTH  word address.
wdata_i  in  WIDTH  write data.
wstrb_i  in  WIDTH/8  byte enables; bit k enables byte k on writes.
clear_i  in  1  one-cycle pulse that requests a zero-fill of all words.
busy_o  out  1  high while a clear is in progress.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response ready.
rsp_data_o  out  WIDTH  read data; 0 for write responses and for errors.
rsp_err_o  out  1  1 = address >= DEPTH.

Behaviour:
- Reset (asynchronous, effective immediately): rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, clear counter=0.
  - FSM goes to CLEAR if INIT_ON_RESET=1, otherwise to IDLE. busy_o follows the FSM.
  - Array contents are not reset.
- Address mapping: bank = addr_i[log2(NUM_BANKS)-1:0]; row = addr_i >> log2(NUM_BANKS).
- FSM states:
  - IDLE: serve requests. A clear_i pulse moves the FSM to CLEAR on the next edge.
  - CLEAR: all banks write 0 to row cnt in parallel; cnt increments from 0 to DEPTH/NUM_BANKS-1. On the final row the FSM returns to IDLE and cnt wraps to 0. Clear therefore takes exactly DEPTH/NUM_BANKS cycles.
- ready_o = (state==IDLE) && !clear_i && (!rsp_valid_o || rsp_ready_i). ready_o is combinational. clear_i wins over a simultaneous valid_i.
- Write, on accept edge:
  - Only the bytes with wstrb_i[k]=1 are updated.
  - wstrb_i=0 is legal: no update, but a response is still returned.
  - The response is loaded on the same edge with data=0 and err=0.
- Read: single-cycle SRAM; rsp_data_o holds the array contents as of before the same-edge access. Latency is one cycle from accept to rsp_valid_o.
- Error: if addr >= DEPTH, the array is not touched and the response is data=0, err=1.
- Response register:
  - Loads on accept.
  - Clears rsp_valid_o when rsp_valid_o && rsp_ready_i and no new accept occurs.
  - Load and drain in the same cycle give back-to-back beats, so sustained throughput is 1 request per cycle when rsp_ready_i=1.
  - While rsp_valid_o=1 and rsp_ready_i=0, rsp_data_o and rsp_err_o hold stable.
- During CLEAR, a pending response still drains normally; new requests stall.
- Reset mid-clear aborts the sequence. Rows not yet cleared keep old data unless INIT_ON_RESET restarts the clear.
- clear_i received during CLEAR is ignored; it does not restart or extend the sequence.
- Request inputs are don't-care when valid_i=0.

Decomposition:
- Shared package mem_pkg contains:
  - the FSM state enum {ST_IDLE, ST_CLEAR};
  - a clog2 helper function;
  - the response-error encoding constants RSP_OK=0 and RSP_ERR=1.
- One natural sub-module, mem_bank: a single-port array of DEPTH/NUM_BANKS x WIDTH with byte-enable write and synchronous read. It is instantiated NUM_BANKS times with a generate loop. The top level owns the FSM, address decode, read mux and response register.

Test Plan:
1. INIT_ON_RESET=1, DEPTH=16, NUM_BANKS=2. Release rst_i, then read addr 5 once busy_o falls -> busy_o high exactly 8 cycles, ready_o low throughout, rsp_data_o=0x0000, rsp_err_o=0.
2. Write addr 3, data 0xA5C3, strb 2'b11. Then write addr 3, data 0x12FF, strb 2'b10. Then read addr 3 -> two write responses with data 0, then read response 0x12C3, err 0.
3. Write addrs 0..15 with data 0x1000+addr, then read them back to back with rsp_ready_i=1 -> ready_o stays high, and 16 read beats arrive on consecutive cycles with 0x1000..0x100F in order.
4. Set rsp_ready_i=0 and issue reads of addr 1 and addr 2 -> addr 1 is accepted, ready_o drops, and rsp_data_o holds stable. Raise rsp_ready_i -> addr 2 is accepted in that same cycle; the next beat carries addr 2's data.
5. Variant DEPTH=12. Write addr 13 with data 0xFFFF, then read addr 13 -> both responses have err=1 and data 0x0000. A read of addr 11 is unaffected.
6. Issue clear_i with a response pending, then assert rst_i at clear cycle 3 with INIT_ON_RESET=0 -> the pending beat completes before reset. After reset busy_o=0, rows 0-2 read 0, and row 3 and above keep their pre-clear data.

Source files
------------

// File: rtl/memory_banked_handshake_pkg.sv
// Shared types and helpers for the banked handshake memory.
// Holds the controller state encoding, response error codes and a clog2 helper.
package mem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_banked_handshake_if.sv
// Request/response bundle between a bus master and the banked memory.
interface memory_banked_handshake_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid_i;
    logic                  ready_o;
    logic                  wr_rd_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wdata_i;
    logic [WIDTH/8-1:0]    wstrb_i;
    logic                  clear_i;
    logic                  busy_o;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WIDTH-1:0]      rsp_data_o;
    logic                  rsp_err_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, clear_i, rsp_ready_i,
        input  ready_o, busy_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, clear_i, rsp_ready_i,
        output ready_o, busy_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/memory_banked_handshake_mem_bank.sv
// One storage bank: single-port array with byte-enable writes and a registered read.
module mem_bank #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 8,
    parameter int ROW_W = 3
) (
    input  logic               clk_i,
    input  logic               en,
    input  logic               we,
    input  logic [ROW_W-1:0]   row,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem_reg [ROWS];

    // rdata only moves on reads, so a stalled response stays stable through writes and clears
    always_ff @(posedge clk_i) begin
        if (en && we) begin
            for (int k = 0; k < WIDTH / 8; k++) begin
                if (be[k]) begin
                    mem_reg[row][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
        if (en && !we) begin
            rdata <= mem_reg[row];
        end
    end
endmodule

// File: rtl/memory_banked_handshake.sv
// Banked handshake SRAM: request decode, clear engine, bank array and response register.
module memory_banked_handshake
    import mem_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int NUM_BANKS     = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    memory_banked_handshake_if.slave bus
);
    localparam int BANK_W = clog2(NUM_BANKS);
    localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int ROW_W  = (clog2(ROWS) > 0) ? clog2(ROWS) : 1;
    localparam int STRB_W = WIDTH / 8;

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [0:0]          S_IDLE   = ST_IDLE;
    localparam logic [0:0]          S_CLEAR  = ST_CLEAR;
    localparam logic [0:0]          S_RESET  = INIT_ON_RESET ? S_CLEAR : S_IDLE;

    logic [0:0]       state_reg, state_next;
    logic [ROW_W-1:0] cnt_reg, cnt_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic             rsp_rd_reg, rsp_rd_next;
    logic [SEL_W-1:0] rsp_bank_reg, rsp_bank_next;

    logic             clearing;
    logic             accept;
    logic             in_range;
    logic [SEL_W-1:0] bank_sel;
    logic [ROW_W-1:0] row_sel;
    logic [WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign clearing = (state_reg == S_CLEAR);
    assign bank_sel = SEL_W'(bus.addr_i & ADDR_WIDTH'(NUM_BANKS - 1));
    assign row_sel  = ROW_W'(bus.addr_i >> BANK_W);
    assign in_range = ({1'b0, bus.addr_i} < DEPTH_C);

    assign bus.ready_o = (state_reg == S_IDLE) && !bus.clear_i &&
                         (!rsp_valid_reg || bus.rsp_ready_i);
    assign accept      = bus.valid_i && bus.ready_o;

    // During a clear every bank zero-fills the same row in parallel
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic bank_en;
            assign bank_en = clearing || (accept && in_range && (bank_sel == SEL_W'(gi)));

            mem_bank #(
                .WIDTH (WIDTH),
                .ROWS  (ROWS),
                .ROW_W (ROW_W)
            ) u_bank (
                .clk_i (clk_i),
                .en    (bank_en),
                .we    (clearing || bus.wr_rd_i),
                .row   (clearing ? cnt_reg : row_sel),
                .be    (clearing ? {STRB_W{1'b1}} : bus.wstrb_i),
                .wdata (clearing ? {WIDTH{1'b0}} : bus.wdata_i),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_rd_next    = rsp_rd_reg;
        rsp_bank_next  = rsp_bank_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.clear_i) begin
                    state_next = S_CLEAR;
                end
            end
            default: begin
                if (cnt_reg == LAST_ROW) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + ROW_W'(1);
                end
            end
        endcase

        // A new accept overrides the drain so beats can go back to back
        if (accept) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = in_range ? RSP_OK : RSP_ERR;
            rsp_rd_next    = in_range && !bus.wr_rd_i;
            rsp_bank_next  = bank_sel;
        end else if (rsp_valid_reg && bus.rsp_ready_i) begin
            rsp_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_RESET;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= RSP_OK;
            rsp_rd_reg    <= 1'b0;
            rsp_bank_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rd_reg    <= rsp_rd_next;
            rsp_bank_reg  <= rsp_bank_next;
        end
    end

    assign bus.busy_o      = clearing;
    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_err_o   = rsp_err_reg;
    assign bus.rsp_data_o  = rsp_rd_reg ? bank_rdata[rsp_bank_reg] : '0;
endmodule

// File: tb/tb_memory_banked_handshake.sv
// Bench for the banked handshake memory: dut_a is 16 deep with clear-on-reset, dut_b is 12 deep without.
module tb_memory_banked_handshake;
    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        sel;
    logic        valid, wr_rd, clear, rsp_ready;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic        ready, busy, rsp_valid, rsp_err, cur_rst;
    logic [15:0] rsp_data;

    rsp_t        exp_q[$];
    int          beat_cyc_q[$];
    rsp_t        mon_e;
    logic [15:0] model [2][16];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_banked_handshake_if #(.WIDTH(16), .ADDR_WIDTH(4)) if_a ();
    memory_banked_handshake_if #(.WIDTH(16), .ADDR_WIDTH(4)) if_b ();

    assign if_a.valid_i     = valid && !sel;
    assign if_a.wr_rd_i     = wr_rd;
    assign if_a.addr_i      = addr;
    assign if_a.wdata_i     = wdata;
    assign if_a.wstrb_i     = wstrb;
    assign if_a.clear_i     = clear && !sel;
    assign if_a.rsp_ready_i = sel ? 1'b1 : rsp_ready;
    assign if_b.valid_i     = valid && sel;
    assign if_b.wr_rd_i     = wr_rd;
    assign if_b.addr_i      = addr;
    assign if_b.wdata_i     = wdata;
    assign if_b.wstrb_i     = wstrb;
    assign if_b.clear_i     = clear && sel;
    assign if_b.rsp_ready_i = sel ? rsp_ready : 1'b1;

    assign ready     = sel ? if_b.ready_o     : if_a.ready_o;
    assign busy      = sel ? if_b.busy_o      : if_a.busy_o;
    assign rsp_valid = sel ? if_b.rsp_valid_o : if_a.rsp_valid_o;
    assign rsp_data  = sel ? if_b.rsp_data_o  : if_a.rsp_data_o;
    assign rsp_err   = sel ? if_b.rsp_err_o   : if_a.rsp_err_o;
    assign cur_rst   = sel ? rst_b            : rst_a;

    memory_banked_handshake #(
        .WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .NUM_BANKS(2), .INIT_ON_RESET(1'b1)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (if_a)
    );

    memory_banked_handshake #(
        .WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .NUM_BANKS(2), .INIT_ON_RESET(1'b0)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (if_b)
    );

    // Scoreboard: every beat that transfers is popped against the queued expectation
    always @(negedge clk) begin
        if (!cur_rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat data=%h err=%b, none expected", rsp_data, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                $display("beat dut=%0d cyc=%0d data=%h err=%b", sel, cyc, rsp_data, rsp_err);
                if ({rsp_data, rsp_err} !== {mon_e.data, mon_e.err}) begin
                    failures++;
                    $display("FAIL rsp_beat got data=%h err=%b want data=%h err=%b",
                             rsp_data, rsp_err, mon_e.data, mon_e.err);
                end
            end
            beat_cyc_q.push_back(cyc);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic req(input logic wr, input logic [3:0] a, input logic [15:0] d,
                       input logic [1:0] s, output int acc_cyc);
        int   depth;
        bit   got;
        rsp_t e;
        depth   = sel ? 12 : 16;
        valid   = 1'b1;
        wr_rd   = wr;
        addr    = a;
        wdata   = d;
        wstrb   = s;
        got     = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL req_timeout addr=%0d ready=%b want 1", a, ready);
        end else begin
            acc_cyc = cyc;
            if (int'(a) >= depth) begin
                e = '{data: 16'h0000, err: 1'b1};
            end else if (wr) begin
                e = '{data: 16'h0000, err: 1'b0};
                for (int k = 0; k < 2; k++) begin
                    if (s[k]) model[sel][a][k*8 +: 8] = d[k*8 +: 8];
                end
            end else begin
                e = '{data: model[sel][a], err: 1'b0};
            end
            exp_q.push_back(e);
            $display("req dut=%0d cyc=%0d wr=%b addr=%0d data=%h strb=%b", sel, cyc, wr, a, d, s);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_cnt, ready_bad, c;
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        valid = 1'b0; clear = 1'b0; rsp_ready = 1'b1;
        wr_rd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < 16; i++) model[0][i] = 16'h0000;
        repeat (3) @(negedge clk);
        checks += 4;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
        if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_a got %b want 1", busy); end
        checks++;
        if (if_b.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy_b got %b want 0", if_b.busy_o); end
        rst_a = 1'b0; rst_b = 1'b0;
        busy_cnt = 0; ready_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                busy_cnt++;
                if (ready) ready_bad++;
            end
            @(negedge clk);
        end
        checks += 2;
        if (busy_cnt != 8) begin failures++; $display("FAIL init_clear_len got %0d want 8", busy_cnt); end
        if (ready_bad != 0) begin failures++; $display("FAIL ready_during_clear got %0d high want 0", ready_bad); end
        @(posedge clk); #1;
        req(1'b0, 4'd5, 16'h0, 2'b00, c);
        wait_drain();
    endtask

    task automatic test_strobe();
        int c;
        req(1'b1, 4'd3, 16'hA5C3, 2'b11, c);
        req(1'b1, 4'd3, 16'h12FF, 2'b10, c);
        req(1'b0, 4'd3, 16'h0000, 2'b00, c);
        req(1'b1, 4'd3, 16'hFFFF, 2'b00, c);
        req(1'b0, 4'd3, 16'h0000, 2'b00, c);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c, prev, bad;
        for (int a = 0; a < 16; a++) req(1'b1, 4'(a), 16'h1000 + 16'(a), 2'b11, c);
        wait_drain();
        beat_cyc_q.delete();
        prev = 0; bad = 0;
        for (int a = 0; a < 16; a++) begin
            req(1'b0, 4'(a), 16'h0, 2'b00, c);
            if (a > 0 && c != prev + 1) bad++;
            prev = c;
        end
        wait_drain();
        checks += 2;
        if (bad != 0) begin failures++; $display("FAIL b2b_accept_gaps got %0d want 0", bad); end
        bad = 0;
        for (int i = 1; i < beat_cyc_q.size(); i++) begin
            if (beat_cyc_q[i] != beat_cyc_q[i-1] + 1) bad++;
        end
        if (beat_cyc_q.size() != 16 || bad != 0) begin
            failures++;
            $display("FAIL b2b_beats got %0d beats %0d gaps want 16 beats 0 gaps", beat_cyc_q.size(), bad);
        end
    endtask

    task automatic test_backpressure();
        int c, c2, raise_cyc;
        rsp_ready = 1'b0;
        req(1'b0, 4'd1, 16'h0, 2'b00, c);
        raise_cyc = -2;
        fork
            req(1'b0, 4'd2, 16'h0, 2'b00, c2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks += 2;
                    if (ready !== 1'b0 || rsp_valid !== 1'b1) begin
                        failures++;
                        $display("FAIL stall_hs got ready=%b valid=%b want 0 1", ready, rsp_valid);
                    end
                    if (rsp_data !== 16'h1001 || rsp_err !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold got %h/%b want 1001/0", rsp_data, rsp_err);
                    end
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
                raise_cyc = cyc;
            end
        join
        checks++;
        if (c2 != raise_cyc) begin
            failures++;
            $display("FAIL bp_accept_cycle got %0d want %0d", c2, raise_cyc);
        end
        wait_drain();
    endtask

    task automatic test_out_of_range();
        int c;
        sel = 1'b1;
        req(1'b1, 4'd13, 16'hFFFF, 2'b11, c);
        req(1'b0, 4'd13, 16'h0, 2'b00, c);
        req(1'b0, 4'd12, 16'h0, 2'b00, c);
        req(1'b1, 4'd11, 16'hBEEF, 2'b11, c);
        req(1'b0, 4'd11, 16'h0, 2'b00, c);
        wait_drain();
    endtask

    task automatic test_clear_reset();
        int c;
        sel = 1'b1;
        for (int a = 0; a < 12; a++) req(1'b1, 4'(a), 16'h2000 + 16'(a), 2'b11, c);
        wait_drain();
        rsp_ready = 1'b0;
        req(1'b0, 4'd7, 16'h0, 2'b00, c);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy got %b want 1", busy); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL clear_drain got %0d pending want 0", exp_q.size()); end
        rst_b = 1'b1;
        for (int a = 0; a < 6; a++) model[1][a] = 16'h0000;
        #2;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midclear_reset got busy=%b valid=%b want 0 0", busy, rsp_valid);
        end
        @(negedge clk);
        rst_b = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got busy=%b ready=%b data=%h err=%b want 0 1 0000 0",
                     busy, ready, rsp_data, rsp_err);
        end
        @(posedge clk); #1;
        for (int a = 0; a < 12; a++) req(1'b0, 4'(a), 16'h0, 2'b00, c);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_clear_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
